ula_arbiter: RTL

ULA_ARBITER -- requirements
Module: ula_arbiter

---
 rtl/ula_arbiter_pkg.sv | 27 ++
 rtl/ula_arbiter_if.sv | 30 +++
 rtl/ula_arbiter_ula.sv | 56 +++++
 rtl/ula_arbiter.sv | 138 +++++++++++++
 4 files changed

// File: rtl/ula_arbiter_pkg.sv
// Shared types and constants for the two-requester ULA arbiter.
// Holds the FSM state type, flag bit positions and opcode constants.
package ula_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Bit positions inside the 4-bit {O,C,S,Z} flag vector
  localparam int FLAG_O = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_S = 1;
  localparam int FLAG_Z = 0;

  localparam logic [4:0] OP_AND = 5'b00000;
  localparam logic [4:0] OP_OR  = 5'b00001;
  localparam logic [4:0] OP_XOR = 5'b00010;
  localparam logic [4:0] OP_ADD = 5'b00100;
  localparam logic [4:0] OP_SUB = 5'b00101;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/ula_arbiter_if.sv
// Request/response bundle between two requesters and the ULA arbiter.
// The master side drives requests and response accepts; the slave is the arbiter.
interface ula_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int OP_W  = 5
);

  logic [1:0]             req_valid;
  logic [1:0]             req_ready;
  logic [1:0][WIDTH-1:0]  req_a;
  logic [1:0][WIDTH-1:0]  req_b;
  logic [1:0][OP_W-1:0]   req_op;
  logic [1:0]             rsp_valid;
  logic [1:0]             rsp_ready;
  logic [WIDTH-1:0]       rsp_result;
  logic [3:0]             rsp_flags;
  logic [3:0]             flags_q;
  logic                   busy;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_flags, flags_q, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_flags, flags_q, busy
  );

endinterface

// File: rtl/ula_arbiter_ula.sv
// ULA_AR: purely combinational arithmetic/logic unit with {O,C,S,Z} flags.
// For SUB the C flag is the unsigned borrow (A < B).
module ULA_AR
  import ula_arbiter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OP_W  = 5
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [OP_W-1:0]  OP,
  output logic [WIDTH-1:0] RESU,
  output logic             O,
  output logic             C,
  output logic             S,
  output logic             Z
);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_dif;
  logic [WIDTH-1:0] w_res;
  logic             w_o;
  logic             w_c;

  assign w_sum = {1'b0, A} + {1'b0, B};
  assign w_dif = {1'b0, A} - {1'b0, B};

  always_comb begin
    w_res = A;
    w_o   = 1'b0;
    w_c   = 1'b0;
    case (OP)
      OP_W'(OP_ADD): begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_o   = (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_W'(OP_SUB): begin
        w_res = w_dif[WIDTH-1:0];
        w_c   = w_dif[WIDTH];
        w_o   = (A[WIDTH-1] != B[WIDTH-1]) && (w_dif[WIDTH-1] != A[WIDTH-1]);
      end
      OP_W'(OP_AND): w_res = A & B;
      OP_W'(OP_OR):  w_res = A | B;
      OP_W'(OP_XOR): w_res = A ^ B;
      default:       w_res = A;
    endcase
  end

  assign RESU = w_res;
  assign O    = w_o;
  assign C    = w_c;
  assign S    = w_res[WIDTH-1];
  assign Z    = (w_res == '0);

endmodule

// File: rtl/ula_arbiter.sv
// Round-robin arbiter sharing one ULA_AR between two requesters.
// A granted request is executed in one cycle and held in RESP until its owner accepts.
//
// state | meaning
// IDLE  | waiting for a request; grant and latch operands
// EXEC  | latched operands drive the ULA; result captured on exit
// RESP  | response presented to owner until its rsp_ready
module ula_arbiter
  import ula_arbiter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OP_W  = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  ula_arbiter_if.slave  bus
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_rr_ptr;
  logic             r_owner;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [OP_W-1:0]  r_op;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_flags;
  logic [3:0]       r_flags_q;

  logic             w_grant;
  logic             w_grant_idx;
  logic [1:0]       w_req_ready;
  logic [1:0]       w_rsp_valid;
  logic [WIDTH-1:0] w_resu;
  logic             w_o;
  logic             w_c;
  logic             w_s;
  logic             w_z;
  logic [3:0]       w_flags;

  // With both requesting, rr_ptr decides; otherwise the lone requester wins
  assign w_grant_idx = (&bus.req_valid) ? r_rr_ptr : bus.req_valid[1];

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_req_ready = 2'b00;
    w_rsp_valid = 2'b00;
    case (r_state)
      ST_IDLE: begin
        if (|bus.req_valid) begin
          w_grant     = 1'b1;
          w_req_ready = onehot2(w_grant_idx);
          w_state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        w_rsp_valid = onehot2(r_owner);
        if (bus.rsp_ready[r_owner]) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= 1'b0;
      r_owner  <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
    end else if (w_grant) begin
      r_rr_ptr <= ~w_grant_idx;
      r_owner  <= w_grant_idx;
      r_a      <= bus.req_a[w_grant_idx];
      r_b      <= bus.req_b[w_grant_idx];
      r_op     <= bus.req_op[w_grant_idx];
    end
  end

  ULA_AR #(
    .WIDTH (WIDTH),
    .OP_W  (OP_W)
  ) u_ula (
    .A    (r_a),
    .B    (r_b),
    .OP   (r_op),
    .RESU (w_resu),
    .O    (w_o),
    .C    (w_c),
    .S    (w_s),
    .Z    (w_z)
  );

  always_comb begin
    w_flags         = 4'b0000;
    w_flags[FLAG_O] = w_o;
    w_flags[FLAG_C] = w_c;
    w_flags[FLAG_S] = w_s;
    w_flags[FLAG_Z] = w_z;
  end

  // flags_q is the architectural copy; it only moves on the EXEC capture edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result  <= '0;
      r_flags   <= 4'b0000;
      r_flags_q <= 4'b0000;
    end else if (r_state == ST_EXEC) begin
      r_result  <= w_resu;
      r_flags   <= w_flags;
      r_flags_q <= w_flags;
    end
  end

  assign bus.req_ready  = w_req_ready;
  assign bus.rsp_valid  = w_rsp_valid;
  assign bus.rsp_result = r_result;
  assign bus.rsp_flags  = r_flags;
  assign bus.flags_q    = r_flags_q;
  assign bus.busy       = (r_state != ST_IDLE);

endmodule
